// File: rtl/result_collector_if.sv
// Handshake bundle between the engine array, the result collector and the
// downstream pixel consumer. The collector sits on the slave modport.
interface result_collector_if #(
    parameter int DATA_WIDTH  = 32,
    parameter int ITER_WIDTH  = 16,
    parameter int NUM_ENGINES = 2
);
    logic [NUM_ENGINES-1:0] eng_valid;
    logic [DATA_WIDTH-1:0]  eng_x    [NUM_ENGINES];
    logic [DATA_WIDTH-1:0]  eng_y    [NUM_ENGINES];
    logic [ITER_WIDTH-1:0]  eng_iter [NUM_ENGINES];
    logic [NUM_ENGINES-1:0] eng_ack;

    logic                   out_valid;
    logic                   out_ready;
    logic [DATA_WIDTH-1:0]  out_x;
    logic [DATA_WIDTH-1:0]  out_y;
    logic [ITER_WIDTH-1:0]  out_iter;

    modport master (
        output eng_valid, eng_x, eng_y, eng_iter, out_ready,
        input  eng_ack, out_valid, out_x, out_y, out_iter
    );

    modport slave (
        input  eng_valid, eng_x, eng_y, eng_iter, out_ready,
        output eng_ack, out_valid, out_x, out_y, out_iter
    );
endinterface

// File: rtl/result_collector.sv
// Round-robin collector: grants one finished engine result per cycle into a
// show-ahead FIFO and streams buffered pixels downstream with valid/ready.
module result_collector #(
    parameter int DATA_WIDTH  = 32,
    parameter int ITER_WIDTH  = 16,
    parameter int NUM_ENGINES = 2,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                         clk,
    input  logic                         reset,
    result_collector_if.slave            bus,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
    output logic [DATA_WIDTH-1:0]        pixel_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int EW = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1;

    logic [EW-1:0]          rr_ptr;
    logic [EW-1:0]          rr_next;
    logic [EW-1:0]          grant_idx;
    logic [EW-1:0]          cand;
    logic                   grant;
    logic [NUM_ENGINES-1:0] eligible;
    logic [NUM_ENGINES-1:0] ack_q;
    logic [NUM_ENGINES-1:0] ack_d;

    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;
    logic                   full;
    logic                   pop;

    logic [DATA_WIDTH-1:0]  mem_x    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0]  mem_y    [FIFO_DEPTH];
    logic [ITER_WIDTH-1:0]  mem_iter [FIFO_DEPTH];

    // An engine being acked this cycle is already captured, so it sits out.
    assign eligible = bus.eng_valid & ~ack_q;
    assign full     = (fifo_count == CW'(FIFO_DEPTH));
    assign pop      = bus.out_valid && bus.out_ready;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        grant     = 1'b0;
        grant_idx = '0;
        cand      = '0;
        ack_d     = '0;
        for (int k = 0; k < NUM_ENGINES; k++) begin
            cand = EW'((int'(rr_ptr) + k) % NUM_ENGINES);
            if (!grant && !full && eligible[cand]) begin
                grant     = 1'b1;
                grant_idx = cand;
            end
        end
        if (grant) begin
            ack_d[grant_idx] = 1'b1;
        end
        rr_next = (grant_idx == EW'(NUM_ENGINES - 1)) ? '0 : grant_idx + 1'b1;
    end

    // NOTE: payload storage has no reset; the count and pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (!reset && grant) begin
            mem_x[wr_ptr]    <= bus.eng_x[grant_idx];
            mem_y[wr_ptr]    <= bus.eng_y[grant_idx];
            mem_iter[wr_ptr] <= bus.eng_iter[grant_idx];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr      <= '0;
            ack_q       <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            fifo_count  <= '0;
            pixel_count <= '0;
        end else begin
            ack_q <= ack_d;
            if (grant) begin
                rr_ptr <= rr_next;
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr      <= rd_ptr + 1'b1;
                pixel_count <= pixel_count + 1'b1;
            end
            case ({grant, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    assign bus.eng_ack   = ack_q;
    assign bus.out_valid = (fifo_count != '0);
    assign bus.out_x     = bus.out_valid ? mem_x[rd_ptr]    : '0;
    assign bus.out_y     = bus.out_valid ? mem_y[rd_ptr]    : '0;
    assign bus.out_iter  = bus.out_valid ? mem_iter[rd_ptr] : '0;
endmodule

// File: tb/tb_result_collector.sv
// Directed bench for result_collector: single result, fairness, backpressure,
// full-with-pop, mid-run reset and a 20-pixel wrap run against a scoreboard.
module tb_result_collector;
    localparam int DW = 32;
    localparam int IW = 16;
    localparam int NE = 2;
    localparam int FD = 8;

    typedef struct packed {
        logic [DW-1:0] x;
        logic [DW-1:0] y;
        logic [IW-1:0] iter;
    } pix_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [3:0]    fifo_count;
    logic [DW-1:0] pixel_count;

    int   total = 0;
    int   bad = 0;
    int   ack_total = 0;
    int   seq [NE];
    pix_t sb [$];
    pix_t head0;
    int   guard;

    always #5 clk = ~clk;

    result_collector_if #(.DATA_WIDTH(DW), .ITER_WIDTH(IW), .NUM_ENGINES(NE)) bus ();

    result_collector #(
        .DATA_WIDTH(DW), .ITER_WIDTH(IW), .NUM_ENGINES(NE), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .fifo_count(fifo_count),
        .pixel_count(pixel_count)
    );

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int e);
        bus.eng_x[e]    = DW'(e * 1000 + seq[e]);
        bus.eng_y[e]    = DW'(seq[e] * 7 + e + 3);
        bus.eng_iter[e] = IW'(seq[e] + 50 * e);
    endtask

    // One clock: compare the head against the scoreboard just before the edge,
    // then record every ack (the data the engine presented when granted).
    task automatic tick();
        pix_t p;
        @(negedge clk);
        if (bus.out_valid) begin
            if (sb.size() == 0) begin
                check("head_without_entry", 80'(bus.out_valid), 80'(0));
            end else begin
                check("head_data", {bus.out_x, bus.out_y, bus.out_iter}, sb[0]);
                if (bus.out_ready) void'(sb.pop_front());
            end
        end
        @(posedge clk);
        #1;
        for (int e = 0; e < NE; e++) begin
            if (bus.eng_ack[e]) begin
                p.x = bus.eng_x[e];
                p.y = bus.eng_y[e];
                p.iter = bus.eng_iter[e];
                sb.push_back(p);
                ack_total++;
                seq[e]++;
                load(e);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        bus.eng_valid = '0;
        bus.out_ready = 1'b0;
        for (int e = 0; e < NE; e++) begin
            seq[e] = 0;
            load(e);
        end

        // Reset state
        tick();
        tick();
        check("rst_count", 80'(fifo_count), 80'(0));
        check("rst_valid", 80'(bus.out_valid), 80'(0));
        check("rst_ack", 80'(bus.eng_ack), 80'(0));
        check("rst_pix", 80'(pixel_count), 80'(0));
        check("rst_out_x", 80'(bus.out_x), 80'(0));

        // Single engine result (5,7,42)
        reset = 1'b0;
        bus.eng_valid = 2'b01;
        bus.eng_x[0] = 32'd5;
        bus.eng_y[0] = 32'd7;
        bus.eng_iter[0] = 16'd42;
        bus.out_ready = 1'b1;
        tick();
        bus.eng_valid = 2'b00;
        check("single_ack", 80'(bus.eng_ack), 80'(2'b01));
        check("single_count", 80'(fifo_count), 80'(1));
        check("single_valid", 80'(bus.out_valid), 80'(1));
        check("single_head", {bus.out_x, bus.out_y, bus.out_iter}, {32'd5, 32'd7, 16'd42});
        tick();
        check("single_ack_drop", 80'(bus.eng_ack), 80'(0));
        check("single_pix", 80'(pixel_count), 80'(1));
        check("single_empty", 80'(bus.out_valid), 80'(0));
        check("empty_out_x", 80'(bus.out_x), 80'(0));
        check("empty_out_iter", 80'(bus.out_iter), 80'(0));

        // Fairness: both valid, grants alternate starting at engine 0
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        bus.eng_valid = 2'b11;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("fair_ack", 80'(bus.eng_ack), (k % 2 == 0) ? 80'(2'b01) : 80'(2'b10));
        end
        bus.eng_valid = 2'b00;
        for (int k = 0; k < 3; k++) tick();
        check("fair_count", 80'(fifo_count), 80'(0));
        check("fair_pix", 80'(pixel_count), 80'(6));

        // Backpressure: exactly 8 acks, then full and silent
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        ack_total = 0;
        bus.out_ready = 1'b0;
        bus.eng_valid = 2'b11;
        tick();
        head0 = {bus.out_x, bus.out_y, bus.out_iter};
        for (int k = 0; k < 11; k++) tick();
        check("bp_acks", 80'(ack_total), 80'(8));
        check("bp_count", 80'(fifo_count), 80'(8));
        check("bp_no_ack", 80'(bus.eng_ack), 80'(0));
        check("bp_head_stable", {bus.out_x, bus.out_y, bus.out_iter}, head0);

        // Full with a pop: 8 -> 7 (no push) -> 8 (push next cycle)
        bus.out_ready = 1'b1;
        tick();
        check("full_pop_count", 80'(fifo_count), 80'(7));
        check("full_pop_no_ack", 80'(bus.eng_ack), 80'(0));
        bus.out_ready = 1'b0;
        tick();
        check("full_refill_count", 80'(fifo_count), 80'(8));
        check("full_refill_acks", 80'(ack_total), 80'(9));
        bus.eng_valid = 2'b00;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        check("bp_drain_count", 80'(fifo_count), 80'(0));
        check("bp_drain_sb", 80'(sb.size()), 80'(0));
        check("bp_drain_pix", 80'(pixel_count), 80'(9));

        // Reset with 3 buffered entries
        bus.out_ready = 1'b0;
        bus.eng_valid = 2'b11;
        for (int k = 0; k < 3; k++) tick();
        bus.eng_valid = 2'b00;
        check("mid_count", 80'(fifo_count), 80'(3));
        reset = 1'b1;
        tick();
        check("mid_rst_count", 80'(fifo_count), 80'(0));
        check("mid_rst_valid", 80'(bus.out_valid), 80'(0));
        check("mid_rst_ack", 80'(bus.eng_ack), 80'(0));
        check("mid_rst_pix", 80'(pixel_count), 80'(0));
        reset = 1'b0;
        sb.delete();
        bus.eng_valid = 2'b01;
        bus.eng_x[0] = 32'h1234;
        bus.eng_y[0] = 32'h5678;
        bus.eng_iter[0] = 16'h9a;
        bus.out_ready = 1'b1;
        tick();
        bus.eng_valid = 2'b00;
        check("post_rst_ack", 80'(bus.eng_ack), 80'(2'b01));
        check("post_rst_head", {bus.out_x, bus.out_y, bus.out_iter}, {32'h1234, 32'h5678, 16'h9a});
        tick();
        check("post_rst_pix", 80'(pixel_count), 80'(1));

        // Wrap: 20 pixels through the depth-8 FIFO with intermittent ready
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sb.delete();
        ack_total = 0;
        bus.eng_valid = 2'b11;
        guard = 0;
        while (ack_total < 20 && guard < 200) begin
            bus.out_ready = (guard % 3 != 2);
            tick();
            guard++;
        end
        bus.eng_valid = 2'b00;
        check("wrap_acks", 80'(ack_total), 80'(20));
        bus.out_ready = 1'b1;
        guard = 0;
        while (fifo_count != 0 && guard < 50) begin
            tick();
            guard++;
        end
        tick();
        check("wrap_count", 80'(fifo_count), 80'(0));
        check("wrap_sb", 80'(sb.size()), 80'(0));
        check("wrap_pix", 80'(pixel_count), 80'(20));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/result_collector.md
RESULT_COLLECTOR -- requirements
Module: result_collector

Interface
REQ-001 Parameter DATA_WIDTH, 32, coordinate width.
REQ-002 Parameter ITER_WIDTH, 16, engine result (iteration count) width.
REQ-003 Parameter NUM_ENGINES, 2, number of engine result ports, at least 1.
REQ-004 Parameter FIFO_DEPTH, 8, output buffer entries, power of 2, at least 2.
REQ-005 clk  input  1  single clock, all state updates on rising edge.
REQ-006 reset  input  1  synchronous, active-high.
REQ-007 eng_valid  input  NUM_ENGINES  bit i high = engine i holds a finished result.
REQ-008 eng_x  input  DATA_WIDTH x NUM_ENGINES (unpacked array)  x coordinate of engine i result.
REQ-009 eng_y  input  DATA_WIDTH x NUM_ENGINES (unpacked array)  y coordinate of engine i result.
REQ-010 eng_iter  input  ITER_WIDTH x NUM_ENGINES (unpacked array)  result of engine i.
REQ-011 eng_ack  output  NUM_ENGINES  one-cycle pulse on bit i = engine i result captured.
REQ-012 out_valid  output  1  head pixel available.
REQ-013 out_ready  input  1  downstream accepts head pixel.
REQ-014 out_x, out_y  output  DATA_WIDTH each  head pixel coordinates.
REQ-015 out_iter  output  ITER_WIDTH  head pixel result.
REQ-016 fifo_count  output  clog2(FIFO_DEPTH)+1  entries currently buffered.
REQ-017 pixel_count  output  DATA_WIDTH  total pixels popped since reset.

Function
REQ-018 Arbitration SHALL be round-robin: eligible = eng_valid[i] && !eng_ack[i]; search starts at rr_ptr, ascending, modulo NUM_ENGINES.
REQ-019 A grant SHALL occur only when fifo_count < FIFO_DEPTH at cycle start; at most one grant per cycle.
REQ-020 On a grant to engine i in cycle N, {eng_x[i], eng_y[i], eng_iter[i]} SHALL be written to the FIFO tail at the end of cycle N.
REQ-021 eng_ack[i] SHALL be registered: high for exactly cycle N+1, low otherwise.
REQ-022 rr_ptr SHALL become (i+1) mod NUM_ENGINES after a grant and SHALL hold when there is no grant.
REQ-023 The FIFO SHALL be show-ahead: out_valid = (fifo_count != 0), and out_x/out_y/out_iter = head entry.
REQ-024 A pop SHALL occur when out_valid && out_ready; head data SHALL stay stable while out_valid && !out_ready.
REQ-025 Simultaneous push and pop SHALL leave fifo_count unchanged.
REQ-026 When full, a pop in the same cycle SHALL NOT enable a push; there is no bypass.
REQ-027 Push into an empty FIFO SHALL make out_valid high in the following cycle (1-cycle latency).
REQ-028 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-029 pixel_count SHALL increment by 1 per pop and wrap from 2^DATA_WIDTH-1 to 0.
REQ-030 out_x/out_y/out_iter SHALL read 0 when the FIFO is empty.

Reset
REQ-031 While reset is high: fifo_count=0, out_valid=0, eng_ack=0, rr_ptr=0, pixel_count=0, pointers=0.
REQ-032 During a reset cycle, no grant, push or pop SHALL occur.
REQ-033 Reset mid-operation SHALL discard buffered entries, and no ack SHALL issue for those entries.
REQ-034 Normal arbitration SHALL resume on the first cycle after reset deasserts.

Verification
REQ-035 Single engine: eng_valid=01, x=5, y=7, iter=42, out_ready=1 -> eng_ack=01 one cycle later; out_valid high one cycle after the push with (5,7,42); pixel_count=1 after the pop.
REQ-036 Fairness: both engines valid continuously with out_ready=1 -> grants alternate 0,1,0,1; no engine is acked twice in a row while the other is waiting.
REQ-037 Backpressure: out_ready=0 with continuous valid from both engines -> exactly 8 acks, then fifo_count=8 and no further acks; head data stable; raising out_ready drains entries in push order.
REQ-038 Full plus simultaneous event: FIFO full, out_ready=1, an engine valid -> pop that cycle, no push; push on the next cycle; fifo_count sequence 8,7,8.
REQ-039 Reset with 3 entries buffered -> next cycle fifo_count=0, out_valid=0, eng_ack=0, pixel_count=0; a fresh result afterwards is delivered normally.
REQ-040 Wrap: 20 pixels streamed through the depth-8 FIFO -> output order equals ack order; pixel_count=20.
